flo_scan_seq: RTL and testbench

- Parametrised, iterative bit-scan unit and successor to the fixed-width find-last-one encoders.
- Accepts a WID-bit vector and scans it CHUNK bits per clock. In FLO mode it returns the index of the highest set bit; in FFO mode it returns the index of the lowest set bit.
- Terminates early on the first chunk containing a hit.
- Sits beside the bit-manipulation datapath for operand widths too wide for a single-cycle combinational encoder.

---
 rtl/flo_scan_seq.sv | 132 +++++++++++++
 tb/tb_flo_scan_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flo_scan_seq.sv
// flo_scan_seq -- iterative find-last-one / find-first-one bit scanner.
//
// A WID-bit vector is latched on accept and walked CHUNK bits per clock.
// In FLO mode the walk runs from the top chunk downwards and reports the
// highest set bit. In FFO mode it runs from chunk 0 upwards and reports the
// lowest set bit. The walk stops on the first chunk containing any set bit,
// or after the final chunk.
//
// Ports:
//   clk_i     clock, all state on the rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   request, accepted when start_i & ready_o
//   mode_i    0 = find last one, 1 = find first one (sampled at accept)
//   abort_i   cancel an in-progress scan (no done_o, results kept)
//   data_i    vector to scan (sampled at accept)
//   ready_o   idle, able to accept
//   busy_o    scan in progress
//   done_o    one-cycle completion pulse
//   found_o   a set bit was found (valid from done_o until next completion)
//   result_o  bit index, or all-ones when nothing was found
module flo_scan_seq #(
  parameter int WID   = 288,
  parameter int CHUNK = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic                       abort_i,
  input  logic [WID-1:0]             data_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       found_o,
  output logic [$clog2(WID+1)-1:0]   result_o
);

  localparam int NCHUNK = (WID + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int OWID   = $clog2(WID + 1);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OFW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t            state;
  logic [PW-1:0]     data_q;
  logic              mode_q;
  logic [CW-1:0]     cnt;

  logic [CHUNK-1:0]  chunk;
  logic              hit;
  logic              last;
  logic [OFW-1:0]    off;
  logic [OWID-1:0]   idx;

  // Offset of the highest set bit within a chunk (0 when the chunk is empty).
  function automatic logic [OFW-1:0] hi_off(input logic [CHUNK-1:0] v);
    hi_off = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (v[i]) hi_off = OFW'(i);
    end
  endfunction

  // Offset of the lowest set bit within a chunk (0 when the chunk is empty).
  function automatic logic [OFW-1:0] lo_off(input logic [CHUNK-1:0] v);
    lo_off = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (v[i]) lo_off = OFW'(i);
    end
  endfunction

  // Chunk currently under examination; constant-base slices keep the mux
  // a plain one-hot selection over NCHUNK candidates.
  always_comb begin
    chunk = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (cnt == CW'(c)) chunk = data_q[c*CHUNK +: CHUNK];
    end
  end

  assign hit  = |chunk;
  assign last = mode_q ? (cnt == CW'(NCHUNK - 1)) : (cnt == '0);
  assign off  = mode_q ? lo_off(chunk) : hi_off(chunk);
  // Full OWID-wide arithmetic: chunk base plus offset never exceeds WID-1.
  assign idx  = OWID'(cnt) * OWID'(CHUNK) + OWID'(off);

  assign ready_o = (state == IDLE);
  assign busy_o  = (state == SCAN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      data_q   <= '0;
      mode_q   <= 1'b0;
      cnt      <= '0;
      done_o   <= 1'b0;
      found_o  <= 1'b0;
      result_o <= '1;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          // abort_i is meaningless here; a coincident start still wins.
          if (start_i) begin
            data_q <= PW'(data_i);
            mode_q <= mode_i;
            cnt    <= mode_i ? '0 : CW'(NCHUNK - 1);
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (hit || last) begin
            state    <= IDLE;
            done_o   <= 1'b1;
            found_o  <= hit;
            result_o <= hit ? idx : '1;
          end else begin
            cnt <= mode_q ? cnt + CW'(1) : cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flo_scan_seq.sv
// Self-checking bench for flo_scan_seq: two instances (288/32 and 256/24),
// a scoreboard of expected completions per instance, and a bit-level
// reference model computing index and chunk count from plain arithmetic.
module tb_flo_scan_seq;

  typedef struct {
    logic       found;
    logic [8:0] res;
    int         cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start [2];
  logic         md    [2];
  logic         abrt  [2];
  logic [287:0] dat   [2];
  logic         ready [2];
  logic         busy  [2];
  logic         done  [2];
  logic         found [2];
  logic [8:0]   res   [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic       lastfound [2];
  logic [8:0] lastres   [2];

  flo_scan_seq #(.WID(288), .CHUNK(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .mode_i(md[0]),
    .abort_i(abrt[0]), .data_i(dat[0]), .ready_o(ready[0]), .busy_o(busy[0]),
    .done_o(done[0]), .found_o(found[0]), .result_o(res[0])
  );

  flo_scan_seq #(.WID(256), .CHUNK(24)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .mode_i(md[1]),
    .abort_i(abrt[1]), .data_i(dat[1][255:0]), .ready_o(ready[1]), .busy_o(busy[1]),
    .done_o(done[1]), .found_o(found[1]), .result_o(res[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: locate the answer bit by bit, then derive how many chunks
  // the walk must visit from which chunk that bit lives in.
  function automatic exp_t model(input logic [287:0] v, input bit m,
                                 input int wid, input int chw);
    exp_t e;
    int   nch = (wid + chw - 1) / chw;
    int   id  = -1;
    for (int i = 0; i < wid; i++) begin
      if (v[i]) begin
        if (!m) id = i;
        else if (id < 0) id = i;
      end
    end
    if (id < 0) begin
      e.found = 1'b0;
      e.res   = 9'((1 << $clog2(wid + 1)) - 1);
      e.cyc   = nch;
    end else begin
      e.found = 1'b1;
      e.res   = 9'(id);
      e.cyc   = m ? (id / chw + 1) : (nch - id / chw);
    end
    return e;
  endfunction

  function automatic logic [287:0] rand_vec();
    logic [287:0] v = '0;
    int sel = $urandom_range(0, 3);
    for (int w = 0; w < 9; w++) begin
      if (sel == 0) v[w*32 +: 32] = $urandom;
      else if ($urandom_range(0, 7) == 0) v[w*32 +: 32] = $urandom & $urandom & $urandom;
    end
    return v;
  endfunction

  // Caller is at a negedge with the instance idle (or in its done cycle).
  task automatic start_scan(input int d, input logic [287:0] v, input bit m, input bit push);
    exp_t e;
    chk($sformatf("ready_at_start%0d", d), int'(ready[d]), 1);
    start[d] = 1'b1;
    dat[d]   = v;
    md[d]    = m;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    abrt[d]  = 1'b0;
    dat[d]   = ~v;
    md[d]    = ~m;
    if (push) begin
      e = model(v, m, (d == 0) ? 288 : 256, (d == 0) ? 32 : 24);
      e.cyc = e.cyc + cyc;
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
      lastfound[d] = e.found;
      lastres[d]   = e.res;
    end
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic wait_done(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done[d]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk($sformatf("done_timeout%0d", d), 0, 1);
  endtask

  task automatic run(input int d, input logic [287:0] v, input bit m);
    start_scan(d, v, m, 1'b1);
    wait_done(d);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done[0]) begin
      if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
      else begin
        e = qa.pop_front();
        chk("found_a", int'(found[0]), int'(e.found));
        chk("result_a", int'(res[0]), int'(e.res));
        chk("latency_a", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done[1]) begin
      if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
      else begin
        e = qb.pop_front();
        chk("found_b", int'(found[1]), int'(e.found));
        chk("result_b", int'(res[1]), int'(e.res));
        chk("latency_b", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic [287:0] v;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; md[d] = 1'b0; abrt[d] = 1'b0; dat[d] = '0;
      lastfound[d] = 1'b0; lastres[d] = 9'h1FF;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", int'(ready[d]), 1);
      chk("rst_busy", int'(busy[d]), 0);
      chk("rst_done", int'(done[d]), 0);
      chk("rst_found", int'(found[d]), 0);
      chk("rst_result", int'(res[d]), 511);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases on the 288/32 instance.
    v = '0; v[287] = 1'b1;
    run(0, v, 1'b0);
    chk("flo_bit287", int'(res[0]), 287);
    v = '0; v[0] = 1'b1;
    run(0, v, 1'b0);
    chk("flo_bit0", int'(res[0]), 0);
    run(0, v, 1'b1);
    chk("ffo_bit0", int'(res[0]), 0);
    run(0, '0, 1'b0);
    chk("flo_zero_found", int'(found[0]), 0);
    run(0, '0, 1'b1);
    chk("ffo_zero_result", int'(res[0]), 511);
    v = '0; v[5] = 1'b1; v[200] = 1'b1;
    run(0, v, 1'b1);
    chk("ffo_5_200", int'(res[0]), 5);
    run(0, v, 1'b0);
    chk("flo_5_200", int'(res[0]), 200);

    // Start while busy must be ignored.
    v = '0; v[0] = 1'b1;
    start_scan(0, v, 1'b0, 1'b1);
    @(negedge clk);
    start[0] = 1'b1; dat[0] = '1; md[0] = 1'b1;
    @(negedge clk);
    chk("busy_hold", int'(busy[0]), 1);
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    // Abort at scan cycle 4 of a 9-chunk scan; the earlier result stays.
    start_scan(0, v, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    abrt[0] = 1'b1;
    @(posedge clk);
    #1 abrt[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_ready", int'(ready[0]), 1);
    chk("abort_result", int'(res[0]), int'(lastres[0]));
    chk("abort_found", int'(found[0]), int'(lastfound[0]));
    repeat (12) @(negedge clk);

    // Abort coinciding with a start in IDLE: start wins.
    abrt[0] = 1'b1;
    v = '0; v[100] = 1'b1;
    run(0, v, 1'b1);

    // Reset at scan cycle 3.
    v = '0; v[0] = 1'b1;
    start_scan(0, v, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(ready[0]), 1);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_result", int'(res[0]), 511);
    chk("midrst_found", int'(found[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '0; v[130] = 1'b1;
    run(0, v, 1'b0);

    // Single-bit sweeps, both modes, both instances.
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < ((d == 0) ? 288 : 256); p++) begin
        v = '0; v[p] = 1'b1;
        run(d, v, 1'b0);
        run(d, v, 1'b1);
      end
    end

    // Random vectors, random mode.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 200; k++) run(d, rand_vec(), 1'($urandom_range(0, 1)));
    end

    run(1, '0, 1'b0);
    chk("b_zero_result", int'(res[1]), 511);

    repeat (15) @(negedge clk);
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
